// File: rtl/lcd_capture.sv
// LCD pixel-stream capture: rebuilds frame geometry from hsync/vsync, packs
// 2-bit pixels four per byte, and double-buffers frames with tear-free swaps.
module lcd_capture #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lcd_hsync,
  input  logic              lcd_vsync,
  input  logic              lcd_pixel,
  input  logic [1:0]        lcd_color,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_d_wr,
  output logic              fb_write,
  output logic              fb_bank,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              frame_err,
  output logic [2:0]        err_flags
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 2);

  typedef enum logic [1:0] {SYNC, LINE, HBLANK, VBLANK} state_t;

  state_t            state_q, state_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        pack_q, pack_d;
  logic              bad_q, bad_d;
  logic [2:0]        err_q, err_d;
  logic              wr_q, wr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              done_q, done_d, ferr_q, ferr_d;
  logic              fb_bank_q, fb_bank_d, disp_bank_q, disp_bank_d;

  logic              hs_rise, hs_fall, vs_rise, vs_fall, pix_ok;
  logic [YW-1:0]     y_inc;
  logic [7:0]        pack_new;
  logic [2:0]        err_set;
  logic              close, frame_bad;

  assign hs_rise = lcd_hsync & ~hsync_q;
  assign hs_fall = ~lcd_hsync & hsync_q;
  assign vs_rise = lcd_vsync & ~vsync_q;
  assign vs_fall = ~lcd_vsync & vsync_q;
  assign pix_ok  = lcd_pixel & ~lcd_hsync & ~lcd_vsync;
  // Saturate one past HEIGHT so runaway frames never wrap back to a legal count.
  assign y_inc   = (y_q > YW'(HEIGHT)) ? y_q : y_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    hsync_d     = lcd_hsync;
    vsync_d     = lcd_vsync;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    pack_d      = pack_q;
    bad_d       = bad_q;
    wr_d        = 1'b0;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
    fb_bank_d   = fb_bank_q;
    disp_bank_d = disp_bank_q;
    err_set     = 3'b000;
    pack_new    = pack_q;
    close       = 1'b0;
    frame_bad   = bad_q;

    case (state_q)
      SYNC: begin
        if (vs_fall) begin
          state_d = LINE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          pack_d  = '0;
          bad_d   = 1'b0;
        end
      end
      LINE: begin
        if (lcd_pixel && !pix_ok) begin
          err_set[1] = 1'b1;
          bad_d      = 1'b1;
        end
        if (vs_rise) begin
          if (x_q != XW'(WIDTH)) err_set[0] = 1'b1;
          close   = 1'b1;
          state_d = VBLANK;
        end else if (hs_rise) begin
          if (x_q != XW'(WIDTH)) begin
            err_set[0] = 1'b1;
            bad_d      = 1'b1;
          end
          state_d = HBLANK;
        end else if (pix_ok) begin
          if (x_q == XW'(WIDTH) || y_q >= YW'(HEIGHT)) begin
            err_set[1] = 1'b1;
            bad_d      = 1'b1;
          end else begin
            pack_new[{x_q[1:0], 1'b0} +: 2] = lcd_color;
            pack_d = pack_new;
            x_d    = x_q + 1'b1;
            if (x_q[1:0] == 2'd3) begin
              wr_d    = 1'b1;
              wdata_d = pack_new;
              waddr_d = base_q + ADDR_W'(x_q >> 2);
            end
          end
        end
      end
      HBLANK: begin
        if (lcd_pixel) begin
          err_set[1] = 1'b1;
          bad_d      = 1'b1;
        end
        if (vs_rise) begin
          close   = 1'b1;
          state_d = VBLANK;
        end else if (hs_fall) begin
          y_d     = y_inc;
          x_d     = '0;
          pack_d  = '0;
          base_d  = base_q + ADDR_W'(WIDTH / 4);
          state_d = LINE;
        end
      end
      VBLANK: begin
        if (lcd_pixel) err_set[1] = 1'b1;
        if (vs_fall) begin
          state_d = LINE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          pack_d  = '0;
          bad_d   = 1'b0;
        end
      end
      default: state_d = SYNC;
    endcase

    // Frame close: an open line counts as finished, then the whole frame is judged.
    if (close) begin
      y_d = y_inc;
      if (y_inc != YW'(HEIGHT)) err_set[2] = 1'b1;
      frame_bad = bad_d | err_set[0] | err_set[2];
      bad_d     = frame_bad;
      if (!frame_bad) begin
        done_d      = 1'b1;
        disp_bank_d = fb_bank_q;
        fb_bank_d   = ~fb_bank_q;
      end else begin
        ferr_d = 1'b1;
      end
    end

    err_d = err_clr ? 3'b000 : (err_q | err_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      pack_q      <= '0;
      bad_q       <= 1'b0;
      err_q       <= 3'b000;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      fb_bank_q   <= 1'b0;
      disp_bank_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      x_q         <= x_d;
      y_q         <= y_d;
      base_q      <= base_d;
      pack_q      <= pack_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      fb_bank_q   <= fb_bank_d;
      disp_bank_q <= disp_bank_d;
    end
  end

  assign fb_addr    = waddr_q;
  assign fb_d_wr    = wdata_q;
  assign fb_write   = wr_q;
  assign fb_bank    = fb_bank_q;
  assign disp_bank  = disp_bank_q;
  assign frame_done = done_q;
  assign frame_err  = ferr_q;
  assign err_flags  = err_q;

endmodule
